// File: rtl/pulse_width_detector.sv
// N-channel isolated-pulse detector accepting widths in [MIN_W, MAX_W] cycles, per-channel polarity.
// Optional PWD_WIDTH_CAPTURE_EN adds width_o, holding the width of each channel's last accepted pulse.
module pulse_width_detector #(
  parameter int unsigned N     = 4,
  parameter int unsigned MIN_W = 1,
  parameter int unsigned MAX_W = 1,
  localparam int unsigned CW   = $clog2(MAX_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     pol,
  output logic [N-1:0]     detected,
  output logic [N-1:0]     overlong
`ifdef PWD_WIDTH_CAPTURE_EN
  ,
  output logic [N*CW-1:0]  width_o
`endif
);

  typedef enum logic [1:0] {
    ST_UNARMED  = 2'd0,
    ST_IDLE     = 2'd1,
    ST_ACTIVE   = 2'd2,
    ST_TOO_LONG = 2'd3
  } state_t;

  for (genvar i = 0; i < int'(N); i++) begin : g_ch
    state_t        state;
    logic [CW-1:0] cnt;
    logic          pol_r;
    logic          ovl_q;
    logic          act;
    logic          pol_chg;

    assign act     = a[i] ^ pol_r;
    assign pol_chg = pol[i] ^ pol_r;

    // A polarity change disarms the channel so a half-seen pulse is never reported.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= ST_UNARMED;
        cnt   <= '0;
        pol_r <= 1'b0;
        ovl_q <= 1'b0;
      end else begin
        pol_r <= pol[i];
        ovl_q <= 1'b0;
        if (pol_chg) begin
          state <= ST_UNARMED;
        end else begin
          case (state)
            ST_UNARMED: begin
              if (!act) state <= ST_IDLE;
            end
            ST_IDLE: begin
              if (act) begin
                state <= ST_ACTIVE;
                cnt   <= CW'(1);
              end
            end
            ST_ACTIVE: begin
              if (!act) begin
                state <= ST_IDLE;
              end else if (cnt == CW'(MAX_W)) begin
                state <= ST_TOO_LONG;
                ovl_q <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
            ST_TOO_LONG: begin
              if (!act) state <= ST_IDLE;
            end
            default: state <= ST_UNARMED;
          endcase
        end
      end
    end

    assign detected[i] = (state == ST_ACTIVE) && !act && !pol_chg && (cnt >= CW'(MIN_W));
    assign overlong[i] = ovl_q;

`ifdef PWD_WIDTH_CAPTURE_EN
    logic [CW-1:0] width_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        width_q <= '0;
      end else if (detected[i]) begin
        width_q <= cnt;
      end
    end

    assign width_o[i*CW +: CW] = width_q;
`endif
  end

endmodule

// File: doc/pulse_width_detector.md
Name: pulse_width_detector

Overview:
- N-channel detector for isolated pulses whose width lies in a programmable window [MIN_W, MAX_W] clock cycles.
- Per-channel polarity selects a high pulse (0→1…1→0) or a low pulse (1→0…0→1).
- Generalises the single-bit 010 detector: N=1, MIN_W=MAX_W=1, pol=0 gives that detector, except for the post-reset arming rule below.
- Sits after input synchronisers in the sequential-basics library and feeds event counters or interrupt logic.

Parameters:
- N, 4, number of independent channels (≥1).
- MIN_W, 1, minimum accepted pulse width in cycles (≥1).
- MAX_W, 1, maximum accepted pulse width in cycles (≥MIN_W).
- Derived, not overridable: CW = $clog2(MAX_W+1), the width of each per-channel counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
- a  input  N  sampled channel inputs.
- pol  input  N  per-channel polarity: 0 = high pulse, 1 = low pulse. Idle level = pol[i], active level = ~pol[i].
- detected  output  N  one-cycle pulse: valid in-window pulse just ended (Mealy).
- overlong  output  N  registered one-cycle pulse: pulse exceeded MAX_W.

Behaviour:
- Channels are fully independent. Per channel: state, counter cnt[CW-1:0], registered copy pol_r.
- Reset (rst=0): state=UNARMED, cnt=0, pol_r=0, overlong=0. detected=0, since it is gated by state.
- States and transitions, evaluated each clk; act = (a[i] != pol_r[i]).
  - UNARMED: !act → IDLE; otherwise stay. A pulse already in progress at reset release is never reported.
  - IDLE: act → ACTIVE with cnt=1; otherwise stay.
  - ACTIVE, act: if cnt==MAX_W → TOO_LONG, overlong=1 next cycle, cnt holds; else cnt=cnt+1.
  - ACTIVE, !act → IDLE. The pulse width is cnt.
  - TOO_LONG: !act → IDLE; otherwise stay. No detected and no further overlong for this pulse.
- detected[i] = (state==ACTIVE) & !act & (cnt >= MIN_W). This is combinational from a and pol_r, asserted in the first idle-level cycle after the pulse, zero added latency.
  - Example, MIN_W=MAX_W=1: a = 0,1,0 on cycles t0..t2 gives detected=1 during t2.
- Pulses shorter than MIN_W end silently in IDLE: no detected, no overlong.
- overlong is registered: high for exactly one cycle, in the cycle after the (MAX_W+1)-th consecutive active sample.
- Back-to-back pulses: the single idle cycle that ends one pulse counts as the idle cycle arming the next. With MIN_W=MAX_W=1, a = 0,1,0,1,0 gives two detections.
- Polarity change: pol_r <= pol every cycle. If pol[i] != pol_r[i], the channel goes to UNARMED next cycle, overriding all other transitions, and detected[i] is forced to 0 in that cycle.
- Reset mid-pulse: all state is cleared asynchronously and the channel must re-arm. A pulse straddling reset deassertion is not reported.
- cnt never exceeds MAX_W, so there is no wrap-around. The counter is sized to hold MAX_W.

Optional Feature:
- Macro: PWD_WIDTH_CAPTURE_EN.
- Defined:
  - Adds output width_o [N*CW-1:0]. Channel i occupies bits [i*CW +: CW].
  - On every cycle where detected[i]=1, that slice loads cnt[i] and holds until the next detection.
  - Resets to 0.
  - overlong does not update it.
- Undefined: no width_o port and no capture registers. All other behaviour is identical.

Test Plan:
- N=1, MIN_W=MAX_W=1, pol=0, reset then a=0,1,0 → detected=1 only on third cycle; a=0,1,1,0 → no detected, overlong=1 in the cycle after the second 1.
- MIN_W=2, MAX_W=4, pol=0: high pulses of widths 1,2,4,5 each separated by two idle cycles → detected for widths 2 and 4 only; overlong once, for the width-5 pulse; width_o=2 then 4 with PWD_WIDTH_CAPTURE_EN.
- pol=1, a held 1 then 1,0,0,1 with MIN_W=1, MAX_W=3 → detected=1 on the cycle a returns to 1.
- Release rst while a=1 (pol=0), a falls after 2 cycles → no detected. Next 010 pulse → detected.
- N=4, different pulses on channels 0 and 3 in the same cycles; toggle pol[1] mid-pulse → only channels 0 and 3 report; channel 1 silent until re-armed.
- Assert rst asynchronously (mid-cycle) while channel is ACTIVE → state, overlong and detected clear immediately without a clock edge.
